// File: rtl/hm3_reg_bus_initiator.sv
// hm3_reg_bus_initiator
// Turns Avalon-MM slave reads/writes (from the HPS lightweight bridge) into
// single-cycle read_reg / write_reg strobes for the GPIO/ADC/touch-sense
// register decoder. The address and write data are held while the decoder
// pipeline runs. Read data is captured after a fixed latency. The master is
// stalled with avs_waitrequest until the access completes.
//
// Ports
//   reg_clk, reset_in        : clock, asynchronous active-high reset
//   avs_address/read/write/writedata, avs_readdata, avs_waitrequest
//                            : Avalon-MM slave side (word address)
//   chip_sel, read_reg, write_reg, busaddress, busdata_out, busdata_in
//                            : decoder strobe bus
//   busy                     : high whenever an access is in flight
module hm3_reg_bus_initiator #(
    parameter int AddrWidth   = 16,
    parameter int BusWidth    = 32,
    parameter int ReadLatency = 4,   // 1..255
    parameter int WriteHold   = 3    // 1..255
) (
    input  logic                 reg_clk,
    input  logic                 reset_in,
    input  logic [AddrWidth-3:0] avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [BusWidth-1:0]  avs_writedata,
    output logic [BusWidth-1:0]  avs_readdata,
    output logic                 avs_waitrequest,
    output logic                 chip_sel,
    output logic                 read_reg,
    output logic                 write_reg,
    output logic [AddrWidth-3:0] busaddress,
    output logic [BusWidth-1:0]  busdata_out,
    input  logic [BusWidth-1:0]  busdata_in,
    output logic                 busy
);

    localparam logic [7:0] LP_RLAT  = 8'(ReadLatency);
    localparam logic [7:0] LP_WHOLD = 8'(WriteHold);

    typedef enum logic [2:0] {
        S_IDLE, S_WSTROBE, S_WHOLD, S_RSTROBE, S_RWAIT, S_DONE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [AddrWidth-3:0]  r_addr;
    logic [BusWidth-1:0]   r_wdata;
    logic [BusWidth-1:0]   r_rdata;
    logic                  r_wait;
    logic                  r_cs;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_busy;

    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wait  <= 1'b1;
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // strobes are single-cycle: only the acceptance branch raises them
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // write has priority if both requests are (illegally) high
                    if (avs_write) begin
                        r_addr  <= avs_address;
                        r_wdata <= avs_writedata;
                        r_cnt   <= LP_WHOLD;
                        r_wr    <= 1'b1;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WSTROBE;
                    end else if (avs_read) begin
                        r_addr  <= avs_address;
                        r_cnt   <= LP_RLAT;
                        r_rd    <= 1'b1;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RSTROBE;
                    end
                end
                S_WSTROBE: r_state <= S_WHOLD;
                S_WHOLD: begin
                    r_cnt <= r_cnt - 8'd1;
                    // count reaches zero on this edge
                    if (r_cnt <= 8'd1) begin
                        r_wait  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_RSTROBE: r_state <= S_RWAIT;
                S_RWAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt <= 8'd1) begin
                        r_rdata <= busdata_in;
                        r_wait  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // always return to IDLE so back-to-back strobes get a low gap
                    r_wait  <= 1'b1;
                    r_cs    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avs_readdata    = r_rdata;
    assign avs_waitrequest = r_wait;
    assign chip_sel        = r_cs;
    assign read_reg        = r_rd;
    assign write_reg       = r_wr;
    assign busaddress      = r_addr;
    assign busdata_out     = r_wdata;
    assign busy            = r_busy;

endmodule

// File: tb/tb_hm3_reg_bus_initiator.sv
// Directed bench for hm3_reg_bus_initiator: default instance with a small
// decoder model, plus two parameter-sweep instances fed by a cycle counter
// so the capture edge can be pinned exactly.
module tb_hm3_reg_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic [13:0] avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;

    // default instance
    logic [31:0] readdata, busdata_out, busdata_in = 32'hDEADBEEF;
    logic [13:0] busaddress;
    logic        waitreq, chip_sel, read_reg, write_reg, busy;
    // sweep instance a: ReadLatency=1, WriteHold=1
    logic [31:0] readdata_a, busdata_out_a;
    logic [13:0] busaddress_a;
    logic        waitreq_a, chip_sel_a, read_reg_a, write_reg_a, busy_a;
    // sweep instance b: ReadLatency=8
    logic [31:0] readdata_b, busdata_out_b;
    logic [13:0] busaddress_b;
    logic        waitreq_b, chip_sel_b, read_reg_b, write_reg_b, busy_b;

    logic [31:0] cyc = '0;
    logic [2:0]  wr_p = '0, rd_p = '0;
    logic [23:0] ddr0 = '0;

    int total = 0;
    int bad = 0;
    int pulses;
    logic [31:0] c0;

    always #5 clk = ~clk;

    hm3_reg_bus_initiator dut (
        .reg_clk(clk), .reset_in(reset_in), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(readdata), .avs_waitrequest(waitreq), .chip_sel(chip_sel),
        .read_reg(read_reg), .write_reg(write_reg), .busaddress(busaddress),
        .busdata_out(busdata_out), .busdata_in(busdata_in), .busy(busy));

    hm3_reg_bus_initiator #(.ReadLatency(1), .WriteHold(1)) dut_a (
        .reg_clk(clk), .reset_in(reset_in), .avs_address(avs_address),
        .avs_read(rd_a), .avs_write(wr_a), .avs_writedata(avs_writedata),
        .avs_readdata(readdata_a), .avs_waitrequest(waitreq_a), .chip_sel(chip_sel_a),
        .read_reg(read_reg_a), .write_reg(write_reg_a), .busaddress(busaddress_a),
        .busdata_out(busdata_out_a), .busdata_in(cyc), .busy(busy_a));

    hm3_reg_bus_initiator #(.ReadLatency(8)) dut_b (
        .reg_clk(clk), .reset_in(reset_in), .avs_address(avs_address),
        .avs_read(rd_b), .avs_write(wr_b), .avs_writedata(avs_writedata),
        .avs_readdata(readdata_b), .avs_waitrequest(waitreq_b), .chip_sel(chip_sel_b),
        .read_reg(read_reg_b), .write_reg(write_reg_b), .busaddress(busaddress_b),
        .busdata_out(busdata_out_b), .busdata_in(cyc), .busy(busy_b));

    // Decoder model: 3-stage write pipeline, read data valid after the 3rd edge.
    always @(posedge clk) begin
        cyc  <= cyc + 32'd1;
        wr_p <= {wr_p[1:0], write_reg};
        rd_p <= {rd_p[1:0], read_reg};
        if (wr_p[2] && busaddress == 14'h440) ddr0 <= busdata_out[23:0];
        if (read_reg) busdata_in <= 32'hDEADBEEF;
        else if (rd_p[1])
            busdata_in <= (busaddress == 14'h448) ? 32'h03020100
                                                  : (32'hA5000000 | {18'h0, busaddress});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset ----
        #1 reset_in = 1'b1;
        #2;
        chk("rst_wait", {31'h0, waitreq}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cs", {31'h0, chip_sel}, 32'h0);
        chk("rst_strb", {30'h0, read_reg, write_reg}, 32'h0);
        chk("rst_addr", {18'h0, busaddress}, 32'h0);
        chk("rst_rdata", readdata, 32'h0);
        step();
        step();
        reset_in = 1'b0;

        // ---- write 0x00ABCDEF to word 0x440 ----
        avs_address = 14'h440; avs_writedata = 32'h00ABCDEF; avs_write = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 5; k++) begin
            step();
            pulses += int'(write_reg);
            chk($sformatf("wr_strobe_E%0d", k), {31'h0, write_reg}, {31'h0, k == 0});
            chk($sformatf("wr_wait_E%0d", k), {31'h0, waitreq}, {31'h0, k != 4});
            chk($sformatf("wr_busy_E%0d", k), {31'h0, busy}, {31'h0, k <= 4});
            if (k <= 4) begin
                chk($sformatf("wr_addr_E%0d", k), {18'h0, busaddress}, 32'h440);
                chk($sformatf("wr_data_E%0d", k), busdata_out, 32'h00ABCDEF);
            end
        end
        avs_write = 1'b0;
        chk("wr_pulses", pulses, 32'd1);
        step();
        chk("wr_ddr0", {8'h0, ddr0}, 32'h00ABCDEF);

        // ---- read word 0x448 ----
        avs_address = 14'h448; avs_read = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 6; k++) begin
            step();
            pulses += int'(read_reg);
            chk($sformatf("rd_strobe_E%0d", k), {31'h0, read_reg}, {31'h0, k == 0});
            chk($sformatf("rd_wait_E%0d", k), {31'h0, waitreq}, {31'h0, k != 5});
            chk($sformatf("rd_busy_E%0d", k), {31'h0, busy}, {31'h0, k <= 5});
            chk($sformatf("rd_cs_E%0d", k), {31'h0, chip_sel}, {31'h0, k <= 5});
            if (k >= 5) chk($sformatf("rd_data_E%0d", k), readdata, 32'h03020100);
        end
        avs_read = 1'b0;
        chk("rd_pulses", pulses, 32'd1);

        // ---- back-to-back write then read, requests held ----
        step();
        avs_address = 14'h441; avs_writedata = 32'h11223344; avs_write = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            step();
            chk($sformatf("b2b_wr_E%0d", k), {31'h0, write_reg}, {31'h0, k == 0});
            chk($sformatf("b2b_rd_E%0d", k), {31'h0, read_reg}, {31'h0, k == 6});
            chk($sformatf("b2b_wait_E%0d", k), {31'h0, waitreq}, {31'h0, k != 4 && k != 11});
            chk($sformatf("b2b_rdata_E%0d", k), readdata,
                (k < 11) ? 32'h03020100 : 32'hA5000449);
            if (k == 5) begin
                avs_write = 1'b0; avs_read = 1'b1; avs_address = 14'h449;
            end
        end
        avs_read = 1'b0;

        // ---- simultaneous read+write: write wins ----
        step();
        avs_address = 14'h442; avs_writedata = 32'h55AA55AA;
        avs_write = 1'b1; avs_read = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            step();
            chk($sformatf("sim_wr_E%0d", k), {31'h0, write_reg}, {31'h0, k == 0});
            chk($sformatf("sim_rd_E%0d", k), {31'h0, read_reg}, 32'h0);
            chk($sformatf("sim_wait_E%0d", k), {31'h0, waitreq}, {31'h0, k != 4});
        end
        avs_write = 1'b0; avs_read = 1'b0;
        chk("sim_data", busdata_out, 32'h55AA55AA);
        chk("sim_rdata", readdata, 32'hA5000449);

        // ---- reset during RWAIT, read held ----
        step();
        avs_address = 14'h448; avs_read = 1'b1;
        step();
        chk("rr_strobe", {31'h0, read_reg}, 32'h1);
        step();
        step();
        reset_in = 1'b1;
        #1;
        chk("rr_wait", {31'h0, waitreq}, 32'h1);
        chk("rr_busy", {31'h0, busy}, 32'h0);
        chk("rr_rdata", readdata, 32'h0);
        chk("rr_strb", {30'h0, read_reg, write_reg}, 32'h0);
        chk("rr_addr", {18'h0, busaddress}, 32'h0);
        step();
        reset_in = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            step();
            chk($sformatf("rr2_strobe_E%0d", k), {31'h0, read_reg}, {31'h0, k == 0});
            chk($sformatf("rr2_wait_E%0d", k), {31'h0, waitreq}, {31'h0, k != 5});
            if (k == 5) chk("rr2_data", readdata, 32'h03020100);
        end
        avs_read = 1'b0;

        // ---- sweep: ReadLatency=1, WriteHold=1 ----
        step();
        avs_address = 14'h0010; avs_writedata = 32'h00000077; wr_a = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            step();
            chk($sformatf("a_wr_strobe_E%0d", k), {31'h0, write_reg_a}, {31'h0, k == 0});
            chk($sformatf("a_wr_wait_E%0d", k), {31'h0, waitreq_a}, {31'h0, k != 2});
        end
        wr_a = 1'b0;
        chk("a_wr_data", busdata_out_a, 32'h00000077);
        step();
        rd_a = 1'b1;
        step();
        c0 = cyc;
        chk("a_rd_strobe", {31'h0, read_reg_a}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("a_rd_wait_E%0d", k), {31'h0, waitreq_a}, {31'h0, k != 2});
            if (k == 2) chk("a_rd_data", readdata_a, c0 + 32'd1);
        end
        rd_a = 1'b0;

        // ---- sweep: ReadLatency=8 ----
        step();
        rd_b = 1'b1;
        step();
        c0 = cyc;
        chk("b_rd_strobe", {31'h0, read_reg_b}, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("b_rd_wait_E%0d", k), {31'h0, waitreq_b}, {31'h0, k != 9});
            if (k == 9) chk("b_rd_data", readdata_b, c0 + 32'd8);
        end
        rd_b = 1'b0;
        chk("b_rd_busy_end", {31'h0, busy_b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
